// File: rtl/reg_file32_if.sv
// Register-file access bundle: two read ports (ID stage) and one write port (WB stage).
// The master side is the pipeline; the slave side is the register file.
interface reg_file32_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rd_data1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
        input  rd_data1, rd_data2
    );

    modport slave (
        input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data,
        output rd_data1, rd_data2
    );
endinterface

// File: rtl/reg_file32.sv
// reg_file32: 2**ADDR_W x DATA_W register file, r0 hardwired to zero, optional WB->ID bypass.
// Reads are combinational (0 cycles), the write lands at the next rising edge; no backpressure.
module reg_file32 #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file32_if.slave   bus
);
    localparam int NREG = 2 ** ADDR_W;

    // Entry 0 has no storage at all; reads of index 0 are forced to zero below.
    logic [DATA_W-1:0] mem [1:NREG-1];

    logic wr_live;
    assign wr_live = bus.wr_en && !rst && (bus.wr_addr != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Read priority: index 0 -> zero, then same-cycle WB forward, then stored value.
    always_comb begin
        bus.rd_data1 = '0;
        if (bus.rd_addr1 != '0) begin
            if (BYPASS && wr_live && (bus.wr_addr == bus.rd_addr1)) begin
                bus.rd_data1 = bus.wr_data;
            end else begin
                bus.rd_data1 = mem[bus.rd_addr1];
            end
        end
    end

    always_comb begin
        bus.rd_data2 = '0;
        if (bus.rd_addr2 != '0) begin
            if (BYPASS && wr_live && (bus.wr_addr == bus.rd_addr2)) begin
                bus.rd_data2 = bus.wr_data;
            end else begin
                bus.rd_data2 = mem[bus.rd_addr2];
            end
        end
    end
endmodule

// File: doc/reg_file32.md
Name: reg_file32

Overview:
- 32-entry x 32-bit general-purpose register file for the pipelined MIPS-Lite CPU.
- It is the read side of the ID stage: two combinational read ports feed the ID/EX pipeline register.
- It has one synchronous write port, driven from the WB stage.
- Register 0 is hardwired to zero.
- An internal write-to-read bypass lets a WB write and an ID read of the same register in the same cycle return the new value.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, register index width (2**ADDR_W entries).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding enabled; 0 = reads return the pre-write stored value.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- rd_addr1  input  ADDR_W  read port 1 index (rs).
- rd_data1  output  DATA_W  read port 1 data.
- rd_addr2  input  ADDR_W  read port 2 index (rt).
- rd_data2  output  DATA_W  read port 2 data.
- wr_en  input  1  write enable from WB stage.
- wr_addr  input  ADDR_W  write index (rd/rt selected by WB).
- wr_data  input  DATA_W  write data.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Sampled only on the rising edge of clk.
- Storage: array of 2**ADDR_W registers, DATA_W bits each. Entry 0 is never physically written.
- Reset:
  - rst=1 at a rising edge clears all entries to 0.
  - wr_en is ignored in that cycle; reset wins over a simultaneous write.
  - While rst=1, read outputs reflect the storage contents (0 after the first reset edge). rst does not gate the read path.
- Write:
  - At the rising edge with rst=0, wr_en=1 and wr_addr!=0: entry[wr_addr] <= wr_data.
  - wr_addr=0: no state change.
  - wr_en=0: no state change.
- Read: combinational, zero latency.
  - rd_dataN = 0 if rd_addrN==0.
  - Else, if BYPASS=1 and wr_en=1 and rst=0 and wr_addr==rd_addrN: rd_dataN = wr_data (same-cycle forwarding).
  - Else rd_dataN = entry[rd_addrN].
- The two read ports are fully independent. Both may address the same register, and both may simultaneously hit the bypass.
- BYPASS=0: a write becomes visible on reads only in the cycle after the write edge.
- No X propagation:
  - After reset, every read returns a defined value.
  - Before the first reset, contents are undefined; the bench must reset first.
- Priority at an edge: rst > write. Read-path priority: addr 0 zero > bypass > stored value.
- Timing: the read path is combinational from rd_addr/wr_* to rd_data. The write path is a single registered stage.

Test Plan:
1. Reset clear: write 32'hDEADBEEF to r5, then assert rst for 1 cycle -> rd_addr1=5 reads 32'h0. Every r1..r31 reads 0 after reset.
2. Basic write/read: write r7=32'h1234_5678 (wr_en=1), then the next cycle set rd_addr1=7 and rd_addr2=7 -> both read 32'h1234_5678. r8 is still 0.
3. Zero register: wr_en=1, wr_addr=0, wr_data=32'hFFFF_FFFF -> rd_addr1=0 reads 0, both in the same cycle and in the following cycle.
4. Bypass: BYPASS=1, r3 holds 32'hA. In the same cycle drive wr_en=1, wr_addr=3, wr_data=32'hB and rd_addr2=3 -> rd_data2=32'hB combinationally before the edge. With BYPASS=0 the same stimulus gives 32'hA before the edge and 32'hB after it.
5. Reset vs write: r9=32'h55 stored. Assert rst=1 together with wr_en=1, wr_addr=9, wr_data=32'h77 -> after the edge r9=0. rd_data with rd_addr=9 during rst shows no bypass of 32'h77.
6. Sweep: write r1..r31 with value (i*32'h0101_0101), then read every pair (i, 31-i) -> each port returns its value. wr_en=0 cycles with a random wr_data change nothing.
